// File: rtl/onehot_seq_pkg.sv
// Shared types for the sequencing one-hot decoder.
// Mode encodings match the mode input; state_t drives the top FSM.
package onehot_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN,
    S_SWEEP
  } state_t;

endpackage

// File: rtl/onehot_seq_decoder_dwell.sv
// Load/decrement dwell counter with terminal-count flag.
// Load has priority; the count stops at zero.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] val_i,
  input  logic               dec_i,
  output logic [DWELL_W-1:0] cnt_o,
  output logic               tc_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == '0);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && !tc_o)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/onehot_seq_decoder.sv
// Registered binary-to-one-hot decoder with DIRECT, SCAN and SWEEP modes.
// Any illegal or changed mode drops through IDLE for one cycle.
module onehot_seq_decoder
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic                    start,
  output logic [(1<<SEL_W)-1:0]   dec_out,
  output logic [SEL_W-1:0]        code_out,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   code_q, code_d;
  logic [OUT_W-1:0]   dec_q, dec_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ld, dn, tc;
  logic [DWELL_W-1:0] ld_val;
  logic [DWELL_W-1:0] cnt;
  mode_t              mode_e;
  logic               seq_mode;

  assign mode_e = mode_t'(mode);
  assign seq_mode = (state_q == S_SCAN) ? (mode_e == MODE_SCAN)
                                        : (mode_e == MODE_SWEEP);

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .dec_i  (dn),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = S_IDLE;
    code_d  = '0;
    dec_d   = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ld      = 1'b1;
    ld_val  = '0;
    dn      = 1'b0;
    if (en && mode_e != MODE_RSVD) begin
      unique case (state_q)
        S_IDLE, S_DIRECT: begin
          if (mode_e == MODE_DIRECT) begin
            state_d = S_DIRECT;
            code_d  = sel_in;
            dec_d   = ONE << sel_in;
            valid_d = 1'b1;
          end else if (state_q == S_IDLE &&
                       (mode_e == MODE_SCAN ||
                        (mode_e == MODE_SWEEP && start))) begin
            state_d = (mode_e == MODE_SCAN) ? S_SCAN : S_SWEEP;
            dec_d   = ONE;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            ld_val  = dwell;
          end
        end
        S_SCAN, S_SWEEP: begin
          if (seq_mode) begin
            if (!tc) begin
              state_d = state_q;
              code_d  = code_q;
              dec_d   = dec_q;
              valid_d = 1'b1;
              busy_d  = 1'b1;
              ld      = 1'b0;
              dn      = 1'b1;
            end else if (state_q == S_SWEEP && (&code_q)) begin
              done_d = 1'b1;
            end else begin
              // Code wraps naturally: OUT_W is exactly 2^SEL_W.
              state_d = state_q;
              code_d  = code_q + 1'b1;
              dec_d   = ONE << code_d;
              valid_d = 1'b1;
              busy_d  = 1'b1;
              ld_val  = dwell;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      dec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dec_out  = dec_q;
  assign code_out = code_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
